ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage_pkg.sv | 33 +++
 rtl/ex_operand_stage_fwd_mux.sv | 32 +++
 rtl/ex_operand_stage.sv | 100 ++++++++++
 tb/tb_ex_operand_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg: shared CPU constants and the EX stage register layout
package ex_operand_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        mem_read;
        logic        reg_write;
    } ex_stage_t;

    // rs2 is a real source for register-register ops and for stores (imm operand, no load, no writeback)
    function automatic logic reads_rs2(input logic alu_src, input logic mem_read, input logic reg_write);
        return !alu_src || (!mem_read && !reg_write);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: priority operand forwarding, MEM result first, then WB (WB path only with EX_WB_FWD_EN)
module fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [4:0]  rs,
    input  logic [31:0] rs_data,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic [31:0] data
);

    logic mem_hit;

    assign mem_hit = mem_reg_write && (mem_rd != REG_X0) && (mem_rd == rs);

`ifdef EX_WB_FWD_EN
    logic wb_hit;

    assign wb_hit = wb_reg_write && (wb_rd != REG_X0) && (wb_rd == rs);
    assign data   = mem_hit ? mem_result : wb_hit ? wb_result : rs_data;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_rd, wb_reg_write, wb_result};
    assign data      = mem_hit ? mem_result : rs_data;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with load-use stall, flush and operand forwarding (WB forwarding with EX_WB_FWD_EN)
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_ctrl,
    input  logic        id_alu_src,
    input  logic        id_mem_read,
    input  logic        id_reg_write,
    input  logic        flush,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [31:0] alu_in_1,
    output logic [31:0] alu_in_2,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  ex_rd,
    output logic        ex_mem_read,
    output logic        ex_reg_write,
    output logic [31:0] ex_store_data
);

    ex_stage_t   ex;
    ex_stage_t   nxt;
    logic        hazard;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    // A load in EX cannot forward to the next instruction, so hold it one cycle; the bubble clears the hazard
    assign hazard = ex.valid && ex.mem_read && (ex.rd != REG_X0) &&
                    ((ex.rd == id_rs1) ||
                     (reads_rs2(id_alu_src, id_mem_read, id_reg_write) && (ex.rd == id_rs2)));

    assign id_ready = flush || !hazard;

    // Next stage contents: accepted instruction, or an all-zero bubble on stall, idle or flush
    always_comb begin
        nxt = '0;
        if (id_valid && id_ready && !flush)
            nxt = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                    alu_ctrl: id_alu_ctrl, alu_src: id_alu_src,
                    mem_read: id_mem_read, reg_write: id_reg_write};
    end

    // Stage register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n)
            ex <= '0;
        else
            ex <= nxt;
    end

    fwd_mux u_fwd_rs1 (
        .rs            (ex.rs1),
        .rs_data       (ex.rs1_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .data          (rs1_fwd)
    );

    fwd_mux u_fwd_rs2 (
        .rs            (ex.rs2),
        .rs_data       (ex.rs2_data),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .data          (rs2_fwd)
    );

    assign ex_valid      = ex.valid;
    assign alu_ctrl      = ex.alu_ctrl;
    assign ex_rd         = ex.rd;
    assign ex_mem_read   = ex.mem_read;
    assign ex_reg_write  = ex.reg_write;
    assign alu_in_1      = rs1_fwd;
    assign alu_in_2      = ex.alu_src ? ex.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard bench for ex_operand_stage, directed vectors
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic        clk, rst_n, id_valid, id_ready, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
    logic [3:0]  id_alu_ctrl, alu_ctrl;
    logic        id_alu_src, id_mem_read, id_reg_write, mem_reg_write, wb_reg_write;
    logic        ex_valid, ex_mem_read, ex_reg_write;
    logic [31:0] alu_in_1, alu_in_2, ex_store_data;

    typedef struct {
        logic [31:0] a1, a2, sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        mr, rw;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;

`ifdef EX_WB_FWD_EN
    localparam logic [31:0] WB_ONLY_EXP = 32'hCC;
`else
    localparam logic [31:0] WB_ONLY_EXP = 32'h33;
`endif

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_ctrl(alu_ctrl), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                         input logic [3:0] ctrl, input logic src, mr, rw);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_ctrl = ctrl; id_alu_src = src; id_mem_read = mr; id_reg_write = rw;
    endtask

    task automatic push(input logic [31:0] a1, a2, sd, input logic [3:0] ctrl,
                        input logic [4:0] rd, input logic mr, rw);
        exp_t e;
        e.a1 = a1; e.a2 = a2; e.sd = sd; e.ctrl = ctrl; e.rd = rd; e.mr = mr; e.rw = rw;
        q.push_back(e);
    endtask

    task automatic fwd(input logic [4:0] mrd, input logic mw, input logic [31:0] mres,
                       input logic [4:0] wrd, input logic ww, input logic [31:0] wres);
        mem_rd = mrd; mem_reg_write = mw; mem_result = mres;
        wb_rd = wrd; wb_reg_write = ww; wb_result = wres;
    endtask

    task automatic run1(input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                        input logic [3:0] ctrl, input logic src, mr, rw,
                        input logic [4:0] mrd, input logic mw, input logic [31:0] mres,
                        input logic [4:0] wrd, input logic ww, input logic [31:0] wres,
                        input logic [31:0] a1, a2, sd);
        issue(rs1, rs2, rd, d1, d2, imm, ctrl, src, mr, rw);
        push(a1, a2, sd, ctrl, rd, mr, rw);
        tick();
        id_valid = 1'b0;
        fwd(mrd, mw, mres, wrd, ww, wres);
        tick();
        fwd(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ex_valid"}, ex_valid, 0);
        chk({p, "_reg_write"}, ex_reg_write, 0);
        chk({p, "_mem_read"}, ex_mem_read, 0);
        chk({p, "_alu_ctrl"}, alu_ctrl, 0);
        chk({p, "_alu_in_1"}, alu_in_1, 0);
        chk({p, "_alu_in_2"}, alu_in_2, 0);
        chk({p, "_ex_rd"}, ex_rd, 0);
        chk({p, "_store_data"}, ex_store_data, 0);
        chk({p, "_id_ready"}, id_ready, 1);
    endtask

    task automatic load_x5();
        issue(1, 0, 5, 32'h100, 0, 4, ALU_ADD, 1, 1, 1);
        push(32'h100, 4, 0, ALU_ADD, 5, 1, 1);
        tick();
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ex_valid) begin
            if (q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_ex: ex_valid=1 with ex_rd=%0d, expected no instruction", ex_rd);
            end else begin
                e = q.pop_front();
                chk("alu_in_1", alu_in_1, e.a1);
                chk("alu_in_2", alu_in_2, e.a2);
                chk("store_data", ex_store_data, e.sd);
                chk("alu_ctrl", alu_ctrl, e.ctrl);
                chk("ex_rd", ex_rd, e.rd);
                chk("mem_read", ex_mem_read, e.mr);
                chk("reg_write", ex_reg_write, e.rw);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        fwd(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        chk_zero("reset");

        run1(1, 2, 4, 5, 9, 7, ALU_ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5, 7, 9);
        run1(3, 6, 10, 32'h11, 32'h22, 0, ALU_OR, 0, 0, 1, 3, 1, 32'hAA, 3, 1, 32'hBB, 32'hAA, 32'h22, 32'h22);
        run1(0, 0, 11, 0, 0, 3, ALU_AND, 1, 0, 1, 0, 1, 32'hFF, 0, 1, 32'hEE, 0, 3, 0);
        run1(7, 0, 12, 32'h33, 0, 0, ALU_SLT, 0, 0, 1, 0, 0, 0, 7, 1, 32'hCC, WB_ONLY_EXP, 0, 0);
        run1(1, 8, 13, 1, 2, 0, ALU_SLL, 0, 0, 1, 8, 1, 32'h5555, 0, 0, 0, 1, 32'h5555, 32'h5555);
        run1(1, 9, 0, 32'h40, 2, 32'h10, ALU_ADD, 1, 0, 0, 9, 1, 32'h77, 0, 0, 0, 32'h40, 32'h10, 32'h77);
        run1(4, 0, 14, 32'h44, 0, 0, ALU_SRA, 0, 0, 1, 4, 0, 32'h99, 0, 0, 0, 32'h44, 0, 0);

        load_x5();
        issue(5, 6, 7, 1, 2, 0, ALU_SUB, 0, 0, 1);
        #1 chk("loaduse_ready", id_ready, 0);
        tick();
        chk("loaduse_bubble", ex_valid, 0);
        chk("loaduse_ready_2nd", id_ready, 1);
        push(32'h500, 2, 2, ALU_SUB, 7, 0, 1);
        tick();
        id_valid = 1'b0;
        fwd(5, 1, 32'h500, 0, 0, 0);
        tick();
        fwd(0, 0, 0, 0, 0, 0);

        load_x5();
        issue(1, 5, 0, 8, 9, 4, ALU_ADD, 1, 0, 0);
        #1 chk("store_rs2_stall", id_ready, 0);
        issue(2, 5, 15, 32'h20, 9, 6, ALU_ADD, 1, 0, 1);
        #1 chk("imm_rs2_no_stall", id_ready, 1);
        push(32'h20, 6, 9, ALU_ADD, 15, 0, 1);
        tick();
        id_valid = 1'b0;
        tick();

        load_x5();
        issue(5, 6, 7, 1, 2, 0, ALU_SUB, 0, 0, 1);
        flush = 1'b1;
        #1 chk("flush_ready", id_ready, 1);
        tick();
        flush = 1'b0;
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_reg_write", ex_reg_write, 0);
        chk("flush_ready_after", id_ready, 1);
        id_valid = 1'b0;
        tick();

        load_x5();
        issue(5, 6, 7, 1, 2, 0, ALU_SUB, 0, 0, 1);
        #1 chk("prereset_stall", id_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero("midreset");
        id_valid = 1'b0;
        repeat (2) tick();

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
